// File: rtl/textbuf_arb.sv
// Shares the single-port text buffer RAM between display reads, a full-buffer clear engine and CPU accesses.
// Latency: display and CPU reads return one cycle after grant; writes complete in the grant cycle.
// Backpressure: display is never stalled; the CPU's valid/ready waits while display reads or a clear are in progress.
module textbuf_arb #(
  parameter int ADDRW     = 11,
  parameter int DATAW     = 32,
  parameter int TXT_DEPTH = 2016
) (
  input  logic             clk_sys,
  input  logic             rst_sys,
  input  logic             disp_req,
  input  logic [ADDRW-1:0] disp_addr,
  output logic [DATAW-1:0] disp_data,
  output logic             disp_valid,
  input  logic             cpu_valid,
  input  logic             cpu_we,
  input  logic [ADDRW-1:0] cpu_addr,
  input  logic [DATAW-1:0] cpu_wdata,
  output logic             cpu_ready,
  output logic [DATAW-1:0] cpu_rdata,
  output logic             cpu_rvalid,
  input  logic             clr_start,
  input  logic [DATAW-1:0] clr_data,
  output logic             clr_busy,
  output logic             ram_en,
  output logic             ram_we,
  output logic [ADDRW-1:0] ram_addr,
  output logic [DATAW-1:0] ram_din,
  input  logic [DATAW-1:0] ram_dout
);

  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_CLEAR = 1'b1
  } state_t;

  // Last word of the buffer; the clear stops here rather than wrapping.
  localparam logic [ADDRW-1:0] LAST_ADDR = ADDRW'(TXT_DEPTH - 1);

  state_t           state;
  state_t           state_nxt;
  logic [ADDRW-1:0] clr_addr;
  logic [DATAW-1:0] clr_fill;
  logic             disp_grant;
  logic             clr_grant;
  logic             cpu_grant;

  // The state register itself is the busy flag, so busy rises the cycle after the start is taken.
  assign clr_busy = (state == ST_CLEAR);

  // Fixed-priority grant: display, then clear, then CPU; nothing is granted while in reset.
  always_comb begin
    disp_grant = 1'b0;
    clr_grant  = 1'b0;
    cpu_grant  = 1'b0;
    if (!rst_sys) begin
      if (disp_req) begin
        disp_grant = 1'b1;
      end else if (clr_busy) begin
        clr_grant = 1'b1;
      end else if (cpu_valid) begin
        cpu_grant = 1'b1;
      end
    end
  end

  assign cpu_ready = cpu_grant;

  // RAM port mux driven straight from the grant; the RAM registers these on its own clock edge.
  always_comb begin
    ram_en   = disp_grant | clr_grant | cpu_grant;
    ram_we   = clr_grant | (cpu_grant & cpu_we);
    ram_addr = '0;
    ram_din  = '0;
    if (disp_grant) begin
      ram_addr = disp_addr;
    end else if (clr_grant) begin
      ram_addr = clr_addr;
      ram_din  = clr_fill;
    end else if (cpu_grant) begin
      ram_addr = cpu_addr;
      ram_din  = cpu_wdata;
    end
  end

  // Clear sequencer next state: start from idle, finish on the granted write of the last word.
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: begin
        if (clr_start) begin
          state_nxt = ST_CLEAR;
        end
      end
      ST_CLEAR: begin
        if (clr_grant && (clr_addr == LAST_ADDR)) begin
          state_nxt = ST_IDLE;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // Clear sequencer state register; reset abandons any clear in progress.
  always_ff @(posedge clk_sys) begin
    if (rst_sys) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Clear address: zeroed on start, advanced only when a clear write actually reaches the RAM.
  always_ff @(posedge clk_sys) begin
    if (rst_sys) begin
      clr_addr <= '0;
    end else if ((state == ST_IDLE) && clr_start) begin
      clr_addr <= '0;
    end else if (clr_grant) begin
      clr_addr <= (clr_addr == LAST_ADDR) ? '0 : clr_addr + ADDRW'(1);
    end
  end

  // Fill word captured when a clear is accepted; it needs no reset since it is only used while busy.
  always_ff @(posedge clk_sys) begin
    if (!rst_sys && (state == ST_IDLE) && clr_start) begin
      clr_fill <= clr_data;
    end
  end

  // Read-return qualifiers line up with the RAM's one-cycle read latency.
  always_ff @(posedge clk_sys) begin
    if (rst_sys) begin
      disp_valid <= 1'b0;
      cpu_rvalid <= 1'b0;
    end else begin
      disp_valid <= disp_grant;
      cpu_rvalid <= cpu_grant & ~cpu_we;
    end
  end

  assign disp_data = ram_dout;
  assign cpu_rdata = ram_dout;

endmodule

// File: tb/tb_textbuf_arb.sv
// Bench for textbuf_arb: drives display, CPU and clear traffic against a buffer model.
// Read responses are checked out of order-free queues by an independent monitor.
// A simple synchronous RAM model stands in for the real buffer instance.
module tb_textbuf_arb;

  localparam int ADDRW = 11;
  localparam int DATAW = 32;
  localparam int DEPTH = 2016;

  typedef struct {
    int          cyc;
    logic [31:0] dat;
  } exp_t;

  logic             clk_sys = 1'b0;
  logic             rst_sys = 1'b1;
  logic             disp_req = 1'b0;
  logic [ADDRW-1:0] disp_addr = '0;
  logic [DATAW-1:0] disp_data;
  logic             disp_valid;
  logic             cpu_valid = 1'b0;
  logic             cpu_we = 1'b0;
  logic [ADDRW-1:0] cpu_addr = '0;
  logic [DATAW-1:0] cpu_wdata = '0;
  logic             cpu_ready;
  logic [DATAW-1:0] cpu_rdata;
  logic             cpu_rvalid;
  logic             clr_start = 1'b0;
  logic [DATAW-1:0] clr_data = '0;
  logic             clr_busy;
  logic             ram_en;
  logic             ram_we;
  logic [ADDRW-1:0] ram_addr;
  logic [DATAW-1:0] ram_din;
  logic [DATAW-1:0] ram_dout;

  textbuf_arb #(.ADDRW(ADDRW), .DATAW(DATAW), .TXT_DEPTH(DEPTH)) dut (
    .clk_sys(clk_sys), .rst_sys(rst_sys),
    .disp_req(disp_req), .disp_addr(disp_addr), .disp_data(disp_data), .disp_valid(disp_valid),
    .cpu_valid(cpu_valid), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_ready(cpu_ready), .cpu_rdata(cpu_rdata), .cpu_rvalid(cpu_rvalid),
    .clr_start(clr_start), .clr_data(clr_data), .clr_busy(clr_busy),
    .ram_en(ram_en), .ram_we(ram_we), .ram_addr(ram_addr), .ram_din(ram_din), .ram_dout(ram_dout)
  );

  always #5 clk_sys = ~clk_sys;

  // Buffer RAM stand-in with registered read data
  logic [31:0] ram [0:2047];
  logic        init_phase = 1'b1;

  function automatic logic [31:0] init_val(input int i);
    return (32'(i) * 32'h9E37_79B1) ^ 32'h5A5A_0000;
  endfunction

  always @(posedge clk_sys) begin
    if (init_phase) begin
      for (int i = 0; i < 2048; i++) ram[i] <= init_val(i);
    end else if (ram_en) begin
      if (ram_we) ram[ram_addr] <= ram_din;
      else        ram_dout <= ram[ram_addr];
    end
  end

  int cyc = 0;
  always @(posedge clk_sys) cyc <= cyc + 1;

  // Reference state: expected buffer contents and the clear in flight
  logic [31:0] ref_mem [0:2047];
  bit          m_busy = 1'b0;
  int          m_next = 0;
  logic [31:0] m_fill = '0;
  bit          acc = 1'b0;
  logic        obs_busy;
  logic        obs_ready;
  exp_t        dq[$];
  exp_t        cq[$];
  bit          mon_en = 1'b0;

  int n_chk = 0;
  int n_pass = 0;

  task automatic chk(input bit ok, input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (ok) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", name, act, exp, cyc);
  endtask

  // One cycle of the reference: who owns the RAM, what the outputs must be, and what changes.
  task automatic model_step();
    logic        e_en, e_we;
    logic [10:0] e_addr;
    logic [31:0] e_din;
    bit          was_busy;
    exp_t        e;
    e_en = 1'b0; e_we = 1'b0; e_addr = '0; e_din = '0;
    acc = 1'b0;
    was_busy = m_busy;
    obs_busy = clr_busy;
    obs_ready = cpu_ready;
    if (!rst_sys) begin
      if (disp_req) begin
        e_en = 1'b1; e_addr = disp_addr;
        e.cyc = cyc + 1; e.dat = ref_mem[disp_addr];
        dq.push_back(e);
      end else if (m_busy) begin
        e_en = 1'b1; e_we = 1'b1; e_addr = 11'(m_next); e_din = m_fill;
      end else if (cpu_valid) begin
        e_en = 1'b1; e_we = cpu_we; e_addr = cpu_addr; e_din = cpu_wdata;
        acc = 1'b1;
        if (!cpu_we) begin
          e.cyc = cyc + 1; e.dat = ref_mem[cpu_addr];
          cq.push_back(e);
        end
      end
    end
    chk(cpu_ready === acc, "cpu_ready", 32'(cpu_ready), 32'(acc));
    chk(clr_busy === m_busy, "clr_busy", 32'(clr_busy), 32'(m_busy));
    chk(ram_en === e_en, "ram_en", 32'(ram_en), 32'(e_en));
    if (e_en) begin
      chk(ram_we === e_we, "ram_we", 32'(ram_we), 32'(e_we));
      chk(ram_addr === e_addr, "ram_addr", 32'(ram_addr), 32'(e_addr));
      if (e_we) chk(ram_din === e_din, "ram_din", ram_din, e_din);
    end
    if (rst_sys) begin
      m_busy = 1'b0;
    end else begin
      if (e_en && e_we) ref_mem[e_addr] = e_din;
      if (!disp_req && m_busy) begin
        if (m_next == DEPTH - 1) m_busy = 1'b0;
        else m_next++;
      end
      if (!was_busy && clr_start) begin
        m_busy = 1'b1; m_fill = clr_data; m_next = 0;
      end
    end
  endtask

  // Inputs are set at the falling edge; this checks them 1 unit later and moves to the next falling edge.
  task automatic tick();
    #1;
    model_step();
    @(negedge clk_sys);
  endtask

  task automatic cpu_op(input bit we, input int addr, input logic [31:0] wdata, input int bound, output int n);
    cpu_valid = 1'b1; cpu_we = we; cpu_addr = 11'(addr); cpu_wdata = wdata;
    n = 0;
    do begin
      tick();
      n++;
    end while (!acc && n < bound);
    chk(obs_ready === 1'b1, "cpu_accept_within_bound", 32'(n), 32'(bound));
    cpu_valid = 1'b0;
  endtask

  task automatic run_clear(input logic [31:0] fill, input bit alt, output int busy_cycles);
    int k;
    clr_start = 1'b1; clr_data = fill;
    tick();
    clr_start = 1'b0;
    busy_cycles = 0; k = 0;
    while (m_busy && k < 6000) begin
      disp_req = alt && k[0];
      disp_addr = 11'($urandom_range(0, DEPTH - 1));
      tick();
      if (obs_busy === 1'b1) busy_cycles++;
      k++;
    end
    disp_req = 1'b0;
  endtask

  // Monitor: pop the expected read return whenever the DUT presents one
  initial begin
    exp_t me;
    forever begin
      @(posedge clk_sys);
      #1;
      if (mon_en) begin
        if (disp_valid === 1'b1) begin
          if (dq.size() == 0) chk(1'b0, "disp_valid_unexpected", 32'(disp_valid), 32'd0);
          else begin
            me = dq.pop_front();
            chk(me.cyc == cyc && disp_data === me.dat, "disp_data", disp_data, me.dat);
          end
        end
        while (dq.size() > 0 && dq[0].cyc <= cyc) begin
          me = dq.pop_front();
          chk(1'b0, "disp_valid_missing", 32'(disp_valid), 32'd1);
        end
        if (cpu_rvalid === 1'b1) begin
          if (cq.size() == 0) chk(1'b0, "cpu_rvalid_unexpected", 32'(cpu_rvalid), 32'd0);
          else begin
            me = cq.pop_front();
            chk(me.cyc == cyc && cpu_rdata === me.dat, "cpu_rdata", cpu_rdata, me.dat);
          end
        end
        while (cq.size() > 0 && cq[0].cyc <= cyc) begin
          me = cq.pop_front();
          chk(1'b0, "cpu_rvalid_missing", 32'(cpu_rvalid), 32'd1);
        end
        chk(!(disp_valid === 1'b1 && cpu_rvalid === 1'b1), "valid_exclusive",
            {30'd0, disp_valid, cpu_rvalid}, 32'd0);
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation exceeded its time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    int n, bc, stalls, mism;
    for (int i = 0; i < 2048; i++) ref_mem[i] = init_val(i);
    repeat (2) @(negedge clk_sys);
    init_phase = 1'b0;
    mon_en = 1'b1;

    // Reset holds everything off even with requests present
    rst_sys = 1'b1; cpu_valid = 1'b1; cpu_we = 1'b1; clr_start = 1'b1;
    tick();
    rst_sys = 1'b0; cpu_valid = 1'b0; cpu_we = 1'b0; clr_start = 1'b0;
    tick();

    // Basic CPU write then read-back
    cpu_op(1'b1, 5, 32'h0041_0F00, 10, n);
    cpu_op(1'b0, 5, '0, 10, n);
    chk(n == 1, "cpu_read_accept_latency", 32'(n), 32'd1);
    tick(); tick();

    // Display and CPU colliding for three cycles
    cpu_valid = 1'b1; cpu_we = 1'b0; cpu_addr = 11'd5;
    stalls = 0;
    for (int i = 0; i < 3; i++) begin
      disp_req = 1'b1; disp_addr = 11'($urandom_range(0, DEPTH - 1));
      tick();
      if (obs_ready === 1'b0) stalls++;
    end
    disp_req = 1'b0;
    tick();
    chk(stalls == 3, "cpu_stalled_by_display", 32'(stalls), 32'd3);
    chk(obs_ready === 1'b1, "cpu_accept_after_display", 32'(obs_ready), 32'd1);
    cpu_valid = 1'b0;
    tick();

    // Full clear with display idle
    run_clear(32'h0020_0700, 1'b0, bc);
    chk(bc == DEPTH, "clear_cycles_idle", 32'(bc), 32'(DEPTH));
    for (int i = 0; i < 6; i++) cpu_op(1'b0, $urandom_range(0, DEPTH - 1), '0, 10, n);
    cpu_op(1'b0, DEPTH - 1, '0, 10, n);

    // Clear with display reading every other cycle
    run_clear(32'h0030_0800, 1'b1, bc);
    chk(bc == 2 * DEPTH - 1, "clear_cycles_interleaved", 32'(bc), 32'(2 * DEPTH - 1));
    cpu_op(1'b0, 0, '0, 10, n);

    // CPU write held across a whole clear, plus a start coinciding with a CPU access
    clr_start = 1'b1; clr_data = 32'h0044_0A00;
    cpu_valid = 1'b1; cpu_we = 1'b1; cpu_addr = 11'd3; cpu_wdata = 32'h1234_5678;
    tick();
    chk(obs_ready === 1'b1, "cpu_wins_start_cycle", 32'(obs_ready), 32'd1);
    clr_start = 1'b0;
    cpu_op(1'b1, 7, 32'hDEAD_BEEF, 2100, n);
    chk(n == DEPTH + 1, "cpu_blocked_for_clear", 32'(n), 32'(DEPTH + 1));
    cpu_op(1'b0, 7, '0, 10, n);
    cpu_op(1'b0, 3, '0, 10, n);

    // Reset part-way through a clear
    cpu_op(1'b1, 100, 32'hCAFE_0100, 10, n);
    clr_start = 1'b1; clr_data = 32'h0055_0B00;
    tick();
    clr_start = 1'b0;
    n = 0;
    while (m_next < 100 && n < 200) begin tick(); n++; end
    rst_sys = 1'b1;
    tick();
    rst_sys = 1'b0;
    tick();
    chk(obs_busy === 1'b0, "busy_drops_after_reset", 32'(obs_busy), 32'd0);
    cpu_op(1'b0, 99, '0, 10, n);
    cpu_op(1'b0, 100, '0, 10, n);
    cpu_op(1'b0, 101, '0, 10, n);

    // Randomised mixed traffic
    for (int i = 0; i < 4000; i++) begin
      disp_req = ($urandom_range(0, 2) == 0);
      disp_addr = 11'($urandom_range(0, DEPTH - 1));
      clr_start = ($urandom_range(0, 999) == 0);
      clr_data = $urandom;
      if (!cpu_valid && $urandom_range(0, 1) == 1) begin
        cpu_valid = 1'b1; cpu_we = 1'($urandom_range(0, 1));
        cpu_addr = 11'($urandom_range(0, DEPTH - 1)); cpu_wdata = $urandom;
      end
      tick();
      if (acc) cpu_valid = 1'b0;
    end
    disp_req = 1'b0; clr_start = 1'b0;
    n = 0;
    while ((m_busy || cpu_valid) && n < 3000) begin
      tick();
      if (acc) cpu_valid = 1'b0;
      n++;
    end
    cpu_valid = 1'b0;
    repeat (3) tick();
    chk(dq.size() == 0 && cq.size() == 0, "responses_drained", 32'(dq.size() + cq.size()), 32'd0);

    mism = 0;
    for (int i = 0; i < 2048; i++) if (ram[i] !== ref_mem[i]) mism++;
    chk(mism == 0, "buffer_contents", 32'(mism), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/textbuf_arb.md
# textbuf_arb

Arbiter and clear sequencer for the single-port text-mode buffer RAM in the chapter 5 display system. It shares the RAM between three requesters. The text display engine's glyph-fetch reads have fixed top priority. A built-in hardware clear engine can fill the whole buffer with one character/colour word. The CPU gets read/write access through a valid/ready handshake. It sits in the `clk_sys` domain between the text display engine, the CPU bus decoder and the RAM instance.

## Interface
- `ADDRW`, 11: buffer address width.
- `DATAW`, 32: buffer word width (glyph code plus colour attributes).
- `TXT_DEPTH`, 2016: words in the buffer (84×24 cells at 672×384 with 8×16 glyphs); must be ≤ 2^ADDRW.

Ports:
- `clk_sys`  in  1  system clock; the only clock.
- `rst_sys`  in  1  synchronous reset, active high.
- `disp_req`  in  1  display read request this cycle.
- `disp_addr`  in  ADDRW  display read address.
- `disp_data`  out  DATAW  display read data (pass-through of `ram_dout`).
- `disp_valid`  out  1  `disp_data` valid.
- `cpu_valid`  in  1  CPU request.
- `cpu_we`  in  1  CPU write (1) / read (0).
- `cpu_addr`  in  ADDRW  CPU address.
- `cpu_wdata`  in  DATAW  CPU write data.
- `cpu_ready`  out  1  CPU request accepted this cycle.
- `cpu_rdata`  out  DATAW  CPU read data (pass-through of `ram_dout`).
- `cpu_rvalid`  out  1  `cpu_rdata` valid.
- `clr_start`  in  1  start a full-buffer clear.
- `clr_data`  in  DATAW  fill word, sampled when `clr_start` is accepted.
- `clr_busy`  out  1  clear in progress.
- `ram_en`  out  1  RAM enable.
- `ram_we`  out  1  RAM write enable.
- `ram_addr`  out  ADDRW  RAM address.
- `ram_din`  out  DATAW  RAM write data.
- `ram_dout`  in  DATAW  RAM read data, registered inside the RAM (1-cycle latency).

## Operation
Per-cycle grant priority, evaluated combinationally:
1. `disp_req` = 1 → display read. Drive `ram_en`=1, `ram_we`=0, `ram_addr`=`disp_addr`.
2. Otherwise, if `clr_busy` = 1 → clear write. Drive `ram_en`=1, `ram_we`=1, `ram_addr`=`clr_addr`, `ram_din`=latched fill word.
3. Otherwise, if `cpu_valid` = 1 → CPU access. Drive `ram_en`=1, `ram_we`=`cpu_we`, `ram_addr`=`cpu_addr`, `ram_din`=`cpu_wdata`.
4. Otherwise `ram_en`=0.

CPU handshake:
- `cpu_ready` = `cpu_valid` & !`disp_req` & !`clr_busy` & !`rst_sys`.
- A transfer occurs when `cpu_valid` & `cpu_ready`.
- The CPU holds `cpu_we`, `cpu_addr` and `cpu_wdata` stable while `cpu_valid` is high and `cpu_ready` is low.
- The CPU is blocked for the whole duration of a clear, so its writes cannot be overwritten by the clear.

Clear FSM:
- IDLE → CLEAR on `clr_start`. Latch `clr_data`, set `clr_addr`=0, set `clr_busy`=1 from the next cycle.
- In CLEAR, `clr_addr` increments only on cycles where the clear write is granted (no `disp_req`).
- The granted write at `clr_addr` = TXT_DEPTH−1 transitions to IDLE. `clr_busy` goes to 0 the following cycle.
- `clr_start` is ignored while in CLEAR.
- `clr_start` in the same cycle as `cpu_valid` while IDLE: the CPU is granted that cycle (the FSM is still IDLE), and the clear begins next cycle.

Read return:
- Registered `disp_valid` = granted display read last cycle.
- Registered `cpu_rvalid` = accepted CPU read last cycle.
- The two are never both 1.
- `disp_data` and `cpu_rdata` are both `ram_dout`, qualified by their valid signal.

Reset:
- `rst_sys` forces the FSM to IDLE, `clr_addr`=0, and `clr_busy`, `disp_valid`, `cpu_rvalid` = 0.
- `ram_en`, `ram_we` and `cpu_ready` are gated to 0 while `rst_sys` is high.
- Reset mid-clear abandons the clear. Words already written stay written.

## Timing
- Display read latency is exactly 1 cycle, with no stalls ever.
- CPU read latency is 1 cycle after acceptance. CPU write completes in the acceptance cycle.
- A full clear takes TXT_DEPTH cycles plus one cycle per `disp_req` cycle during it (2016 cycles if display idle).
- Address arithmetic: `clr_addr` is ADDRW bits; the terminal compare is against TXT_DEPTH−1 and never wraps.
- `ram_*` outputs are combinational from inputs and state, which suits a RAM that registers its inputs.

## Test plan
- Reset, then CPU write 0x00410F00 to addr 5 with display idle. Then CPU read addr 5 → `cpu_ready` high in the request cycle; `cpu_rvalid`=1 with `cpu_rdata`=0x00410F00 one cycle after the read.
- `disp_req` and `cpu_valid` held together for 3 cycles → `cpu_ready`=0 for 3 cycles; `disp_valid` pulses 1 cycle after each request; CPU accepted on the 4th cycle.
- `clr_start` with `clr_data`=0x00200700, display idle → `clr_busy` high for 2016 cycles; addresses 0..2015 written in order; every word reads back 0x00200700.
- Clear with `disp_req` high on every other cycle → display never stalls; clear takes 4031 cycles; no address skipped or written twice.
- `cpu_valid` write held during a clear → `cpu_ready`=0 until `clr_busy` falls; write lands afterwards and survives.
- `rst_sys` asserted at `clr_addr`=100 → `clr_busy`=0 the next cycle; addr 99 holds the fill word; addr 100 is unchanged.
